// File: rtl/ext_req_arbiter_if.sv
// Request/result bundle between field producers and the shared extension datapath.
// The slave side is the arbiter; the master side is the producer/consumer environment.
interface ext_req_arbiter_if #(
    parameter int NREQ = 4,
    parameter int Q    = 2,
    parameter int R    = 25,
    parameter int SW   = 3,
    parameter int CW   = 16
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*Q-1:0] req_data;
    logic [NREQ-1:0]   req_zext;
    logic [NREQ-1:0]   req_ready;
    logic              out_valid;
    logic              out_ready;
    logic [R-1:0]      out_data;
    logic [SW-1:0]     out_src;
    logic              out_zext;
    logic [CW-1:0]     grant_cnt;

    modport slave (
        input  req_valid, req_data, req_zext, out_ready,
        output req_ready, out_valid, out_data, out_src, out_zext, grant_cnt
    );

    modport master (
        output req_valid, req_data, req_zext, out_ready,
        input  req_ready, out_valid, out_data, out_src, out_zext, grant_cnt
    );
endinterface

// File: rtl/ext_req_arbiter.sv
// Round-robin arbiter sharing one registered sign/zero extension stage among NREQ requesters.
// The single output register refills in the same cycle it drains, giving one result per cycle.
module ext_req_arbiter #(
    parameter int NREQ = 4,
    parameter int Q    = 2,
    parameter int R    = 25,
    parameter int SW   = 3,
    parameter int CW   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    ext_req_arbiter_if.slave  bus
);
    logic [R-1:0]  out_data_q,  out_data_d;
    logic [SW-1:0] out_src_q,   out_src_d;
    logic          out_zext_q,  out_zext_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] rr_ptr_q,    rr_ptr_d;
    logic [CW-1:0] grant_cnt_q, grant_cnt_d;

    logic          load_ok;
    logic          found;
    logic          accept;
    logic [SW-1:0] win;
    logic [SW:0]   idx;
    logic [Q-1:0]  field;
    logic [R-1:0]  ext_val;

    assign load_ok = !out_valid_q || bus.out_ready;

    // Scan from rr_ptr upward with modulo wrap; the extra idx bit keeps ptr+k from overflowing.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, rr_ptr_q} + (SW+1)'(k);
            if (idx >= (SW+1)'(NREQ)) begin
                idx = idx - (SW+1)'(NREQ);
            end
            if (!found && bus.req_valid[idx[SW-1:0]]) begin
                found = 1'b1;
                win   = idx[SW-1:0];
            end
        end
    end

    assign accept        = load_ok && found;
    assign bus.req_ready = accept ? (NREQ'(1) << win) : '0;

    assign field   = bus.req_data[win*Q +: Q];
    assign ext_val = bus.req_zext[win] ? {{(R-Q){1'b0}}, field}
                                       : {{(R-Q){field[Q-1]}}, field};

    always_comb begin
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_zext_d  = out_zext_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        grant_cnt_d = grant_cnt_q;
        if (accept) begin
            out_data_d  = ext_val;
            out_src_d   = win;
            out_zext_d  = bus.req_zext[win];
            out_valid_d = 1'b1;
            rr_ptr_d    = (win == SW'(NREQ-1)) ? '0 : win + SW'(1);
            grant_cnt_d = grant_cnt_q + CW'(1);
        end else if (load_ok) begin
            // Drained with nothing to refill; payload registers keep their last values.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_zext_q  <= 1'b0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
            grant_cnt_q <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_zext_q  <= out_zext_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.out_zext  = out_zext_q;
    assign bus.out_valid = out_valid_q;
    assign bus.grant_cnt = grant_cnt_q;
endmodule
